// File: rtl/register_file_vectorial.sv
// Vector register file: NUM_VECTORES registers of VECTOR_SIZE lanes x WIDTH bits,
// two combinational read ports and one synchronous write port, no write-to-read bypass.
module register_file_vectorial #(
  parameter  int WIDTH        = 16,
  parameter  int VECTOR_SIZE  = 16,
  parameter  int NUM_VECTORES = 8,
  localparam int IDX_W        = $clog2(NUM_VECTORES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [IDX_W-1:0] v1,
  input  logic [IDX_W-1:0] v2,
  input  logic [IDX_W-1:0] v3,
  input  logic [WIDTH-1:0] wd3 [VECTOR_SIZE-1:0],
  output logic [WIDTH-1:0] vd1 [VECTOR_SIZE-1:0],
  output logic [WIDTH-1:0] vd2 [VECTOR_SIZE-1:0]
);

  localparam logic [IDX_W:0] NUM_VEC_L = NUM_VECTORES[IDX_W:0];

  logic [WIDTH-1:0] regs_q [NUM_VECTORES-1:0][VECTOR_SIZE-1:0];
  logic [WIDTH-1:0] regs_d [NUM_VECTORES-1:0][VECTOR_SIZE-1:0];

  logic v1_ok, v2_ok, v3_ok;

  // Index range checks only matter for non-power-of-two register counts.
  assign v1_ok = ({1'b0, v1} < NUM_VEC_L);
  assign v2_ok = ({1'b0, v2} < NUM_VEC_L);
  assign v3_ok = ({1'b0, v3} < NUM_VEC_L);

  always_comb begin
    regs_d = regs_q;
    if (we3 && v3_ok) begin
      for (int l = 0; l < VECTOR_SIZE; l++) begin
        regs_d[v3][l] = wd3[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_VECTORES; r++) begin
        for (int l = 0; l < VECTOR_SIZE; l++) begin
          regs_q[r][l] <= '0;
        end
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int l = 0; l < VECTOR_SIZE; l++) begin
      vd1[l] = '0;
      vd2[l] = '0;
    end
    if (v1_ok) begin
      for (int l = 0; l < VECTOR_SIZE; l++) begin
        vd1[l] = regs_q[v1][l];
      end
    end
    if (v2_ok) begin
      for (int l = 0; l < VECTOR_SIZE; l++) begin
        vd2[l] = regs_q[v2][l];
      end
    end
  end

endmodule

// File: tb/tb_register_file_vectorial.sv
// Directed bench for register_file_vectorial: reset, write/read, gating,
// same-index read-during-write, register 0 writability and reset priority.
module tb_register_file_vectorial;

  localparam int WIDTH        = 16;
  localparam int VECTOR_SIZE  = 16;
  localparam int NUM_VECTORES = 8;
  localparam int IDX_W        = $clog2(NUM_VECTORES);

  logic             clk;
  logic             rst_n;
  logic             we3;
  logic [IDX_W-1:0] v1, v2, v3;
  logic [WIDTH-1:0] wd3 [VECTOR_SIZE-1:0];
  logic [WIDTH-1:0] vd1 [VECTOR_SIZE-1:0];
  logic [WIDTH-1:0] vd2 [VECTOR_SIZE-1:0];

  int n_checks;
  int n_fail;

  register_file_vectorial #(
    .WIDTH(WIDTH),
    .VECTOR_SIZE(VECTOR_SIZE),
    .NUM_VECTORES(NUM_VECTORES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .we3(we3),
    .v1(v1),
    .v2(v2),
    .v3(v3),
    .wd3(wd3),
    .vd1(vd1),
    .vd2(vd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int lane,
                          input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s lane=%0d got=%h expected=%h", tag, lane, obs, exp);
    end
  endtask

  task automatic fill_wd3(input logic [WIDTH-1:0] val);
    for (int l = 0; l < VECTOR_SIZE; l++) wd3[l] = val;
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vd1_const(input string tag, input logic [WIDTH-1:0] exp);
    #1;
    for (int l = 0; l < VECTOR_SIZE; l++) check_eq(tag, l, vd1[l], exp);
  endtask

  task automatic check_vd2_const(input string tag, input logic [WIDTH-1:0] exp);
    #1;
    for (int l = 0; l < VECTOR_SIZE; l++) check_eq(tag, l, vd2[l], exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    we3   = 1'b0;
    v1 = '0; v2 = '0; v3 = '0;
    fill_wd3('0);

    // Reset for one edge, then release.
    step();
    rst_n = 1'b1;
    v1 = 3'd0; v2 = 3'd7;
    check_vd1_const("reset_vd1_r0", 16'h0000);
    check_vd2_const("reset_vd2_r7", 16'h0000);

    // Write ABCD into register 2.
    we3 = 1'b1; v3 = 3'd2; fill_wd3(16'hABCD);
    step();
    we3 = 1'b0;
    v1 = 3'd2; v2 = 3'd1;
    check_vd1_const("wr_r2_vd1", 16'hABCD);
    check_vd2_const("wr_r1_vd2_zero", 16'h0000);

    // Second write must not disturb register 2.
    we3 = 1'b1; v3 = 3'd4; fill_wd3(16'h1111);
    step();
    we3 = 1'b0;
    v1 = 3'd2; v2 = 3'd4;
    check_vd1_const("wr2_r2_kept", 16'hABCD);
    check_vd2_const("wr2_r4", 16'h1111);

    // Unwritten registers and write-enable gating.
    v1 = 3'd7; v2 = 3'd6;
    check_vd1_const("unwritten_r7", 16'h0000);
    check_vd2_const("unwritten_r6", 16'h0000);
    we3 = 1'b0; v3 = 3'd7; fill_wd3(16'h5555);
    step();
    v1 = 3'd7;
    check_vd1_const("we_gated_r7", 16'h0000);

    // Same-index read during write: old value before the edge, new after.
    v1 = 3'd3; v3 = 3'd3; we3 = 1'b1;
    for (int l = 0; l < VECTOR_SIZE; l++) wd3[l] = WIDTH'(l);
    check_vd1_const("rdw_before_edge", 16'h0000);
    step();
    we3 = 1'b0;
    #1;
    for (int l = 0; l < VECTOR_SIZE; l++) check_eq("rdw_after_edge", l, vd1[l], WIDTH'(l));

    // Register 0 is writable; equal read indices give identical data.
    we3 = 1'b1; v3 = 3'd0;
    for (int l = 0; l < VECTOR_SIZE; l++) wd3[l] = WIDTH'(16'h0F00 + l * 3);
    step();
    we3 = 1'b0;
    v1 = 3'd0; v2 = 3'd0;
    #1;
    for (int l = 0; l < VECTOR_SIZE; l++) begin
      check_eq("r0_vd1", l, vd1[l], WIDTH'(16'h0F00 + l * 3));
      check_eq("r0_vd2", l, vd2[l], WIDTH'(16'h0F00 + l * 3));
    end

    // Reset wins over a simultaneous write and clears prior contents.
    rst_n = 1'b0; we3 = 1'b1; v3 = 3'd2; fill_wd3(16'hFFFF);
    step();
    rst_n = 1'b1; we3 = 1'b0;
    v1 = 3'd2; v2 = 3'd4;
    check_vd1_const("rst_prio_r2", 16'h0000);
    check_vd2_const("rst_clr_r4", 16'h0000);
    v1 = 3'd3; v2 = 3'd0;
    check_vd1_const("rst_clr_r3", 16'h0000);
    check_vd2_const("rst_clr_r0", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_vectorial.md
Name: register_file_vectorial

Overview:
- Vector register file: NUM_VECTORES vector registers, each VECTOR_SIZE lanes of WIDTH bits.
- Two combinational read ports (vd1, vd2) and one synchronous write port (wd3).
- Sits in the decode stage of the vector datapath and feeds vector operands to the vector ALU.
- Writes the vector result back in from the writeback stage.

Parameters:
- WIDTH, 16, bits per lane (element width).
- VECTOR_SIZE, 16, lanes per vector register.
- NUM_VECTORES, 8, number of vector registers. Must be ≥2; register index width is $clog2(NUM_VECTORES).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- we3  input  1  write enable for write port 3.
- v1  input  $clog2(NUM_VECTORES)  read-port-1 register index.
- v2  input  $clog2(NUM_VECTORES)  read-port-2 register index.
- v3  input  $clog2(NUM_VECTORES)  write-port register index.
- wd3  input  unpacked array [VECTOR_SIZE-1:0] of WIDTH bits  write data, one element per lane.
- vd1  output  unpacked array [VECTOR_SIZE-1:0] of WIDTH bits  read data for v1.
- vd2  output  unpacked array [VECTOR_SIZE-1:0] of WIDTH bits  read data for v2.

Behaviour:
- Storage: NUM_VECTORES × VECTOR_SIZE × WIDTH flops, indexed [vector][lane]. Lane i of wd3 is stored in lane i of the target register; no lane permutation.
- Reset: on a rising edge with rst_n=0, every lane of every register clears to 0. Reset has priority over a simultaneous write (we3=1 ignored that cycle).
- Reset mid-operation: contents are lost. Reads of any index return all zeros immediately after the reset edge.
- Write: on a rising edge with rst_n=1 and we3=1, reg[v3] <= wd3, all lanes at once. Other registers are unchanged.
- No write occurs when we3=0; all registers hold.
- Write latency: 1 cycle. New data is visible on vd1/vd2 after the rising edge that performs the write.
- Read: vd1 = reg[v1] and vd2 = reg[v2], purely combinational. They change within the same cycle as v1/v2 change.
- No clock or enable on reads. v1 and v2 may be equal, giving identical outputs.
- Read-during-write to the same index: no bypass. Before the edge, the read returns the old contents; after the edge, the new contents.
- All registers are writable; register 0 is not hardwired.
- Unwritten registers read back as 0 after reset.
- With non-power-of-two NUM_VECTORES, out-of-range indices:
  - Reads return all zeros.
  - Writes are ignored.
- Outputs are never X after the first reset.

Test Plan:
- Reset: hold rst_n=0 for 1 edge, then release. Read v1=0, v2=7 → all 16 lanes of vd1 and vd2 = 16'h0000.
- Write/read: we3=1, v3=2, all wd3 lanes = 16'hABCD, one edge, then we3=0. Set v1=2, v2=1 → vd1[0], vd1[10], vd1[15] (all lanes) = 16'hABCD; vd2 all lanes = 16'h0000.
- Second write, no disturbance: write all lanes of v3=4 with 16'h1111. Read v1=2, v2=4 → vd1 all lanes = 16'hABCD; vd2 all lanes = 16'h1111.
- Unwritten registers and write-enable gating:
  - Read v1=7, v2=6 → all zeros.
  - Then apply we3=0, v3=7, wd3=16'h5555 for one edge → v1=7 still reads 0.
- Same-index read during write: v1=v3=3, we3=1, wd3 lanes = lane index (0..15).
  - Before the edge: vd1 = old value (0).
  - After the edge: vd1[i] = i.
- Reset priority and mid-operation reset: rst_n=0 with we3=1, v3=2, wd3=16'hFFFF on the same edge → v1=2 reads 0 and v2=4 reads 0 (prior 16'h1111 cleared).
